mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 142 ++++++++++++++
 tb/tb_mc_control_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: registered FSM state plus combinational
// datapath controls decoded from the current state and opcode.
module mc_control_unit (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       sign,
   output logic       PCWre,
   output logic       IRWre,
   output logic       RegWre,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic       WrRegDSrc,
   output logic       ExtSel,
   output logic [1:0] RegDst,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLTI  = 6'b100110;
   localparam logic [5:0] OP_SLT   = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   state_t cur, nxt;
   logic   is_alu, is_lw, is_sw, is_br, is_halt, is_jmp, taken;

   always_ff @(posedge CLK) begin
      if (Reset) cur <= S_IF;
      else       cur <= nxt;
   end

   always_comb begin
      is_alu  = op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
                           OP_ORI, OP_SLL, OP_SLTI, OP_SLT};
      is_lw   = (op == OP_LW);
      is_sw   = (op == OP_SW);
      is_br   = op inside {OP_BEQ, OP_BNE, OP_BLTZ};
      is_halt = (op == OP_HALT);
      // j, jr, jal and every undecoded opcode finish in ID
      is_jmp  = !(is_alu || is_lw || is_sw || is_br || is_halt);
      taken   = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero) ||
                ((op == OP_BLTZ) && sign);

      nxt = S_IF;
      unique case (cur)
         S_IF:     nxt = S_ID;
         S_ID: begin
            if (is_alu)              nxt = S_EXE_AL;
            else if (is_lw || is_sw) nxt = S_EXE_LS;
            else if (is_br)          nxt = S_EXE_BR;
            else if (is_halt)        nxt = S_ID;
            else                     nxt = S_IF;
         end
         S_EXE_AL: nxt = S_WB_AL;
         S_WB_AL:  nxt = S_IF;
         S_EXE_BR: nxt = S_IF;
         S_EXE_LS: nxt = S_MEM;
         S_MEM:    nxt = is_lw ? S_WB_LD : S_IF;
         S_WB_LD:  nxt = S_IF;
         default:  nxt = S_IF;
      endcase
   end

   always_comb begin
      IRWre  = (cur == S_IF);
      PCWre  = (cur == S_WB_AL) || (cur == S_WB_LD) || (cur == S_EXE_BR) ||
               ((cur == S_MEM) && is_sw) || ((cur == S_ID) && is_jmp);
      RegWre = (cur == S_WB_AL) || (cur == S_WB_LD) ||
               ((cur == S_ID) && (op == OP_JAL));
      mRD    = (cur == S_MEM) && is_lw;
      mWR    = (cur == S_MEM) && is_sw;

      PCSrc = 2'b00;
      if ((cur == S_EXE_BR) && taken)                          PCSrc = 2'b01;
      else if ((cur == S_ID) && ((op == OP_J) || (op == OP_JAL))) PCSrc = 2'b11;
      else if ((cur == S_ID) && (op == OP_JR))                 PCSrc = 2'b10;

      if (op == OP_JAL)                                     RegDst = 2'b00;
      else if (op inside {OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT}) RegDst = 2'b10;
      else                                                  RegDst = 2'b01;

      WrRegDSrc = (op != OP_JAL);
      DBDataSrc = is_lw;
      ALUSrcA   = (op == OP_SLL);
      ALUSrcB   = op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW};
      ExtSel    = !((op == OP_ANDI) || (op == OP_ORI));

      unique case (op)
         OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ALUOp = 3'b001;
         OP_AND, OP_ANDI:                 ALUOp = 3'b100;
         OP_ORI:                          ALUOp = 3'b011;
         OP_SLL:                          ALUOp = 3'b010;
         OP_SLT, OP_SLTI:                 ALUOp = 3'b110;
         default:                         ALUOp = 3'b000;
      endcase

      // Reset masks every side effect while the state register is being forced
      if (Reset) begin
         IRWre  = 1'b0;
         PCWre  = 1'b0;
         RegWre = 1'b0;
         mRD    = 1'b0;
         mWR    = 1'b0;
         PCSrc  = 2'b00;
         ALUOp  = 3'b000;
      end

      state = cur;
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-instruction phase model,
// directed pins and randomized instruction streams with mid-instruction resets.
module tb_mc_control_unit;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] op = 6'b0;
   logic       zero = 1'b0;
   logic       sign = 1'b0;
   logic       PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc;
   logic       mRD, mWR, WrRegDSrc, ExtSel;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp, state;

   mc_control_unit dut (
      .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
      .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
      .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel), .RegDst(RegDst),
      .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
   );

   always #5 CLK = ~CLK;

   localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND = 6'b010000, OP_ANDI = 6'b010001, OP_ORI = 6'b010010;
   localparam logic [5:0] OP_SLL = 6'b011000, OP_SLTI = 6'b100110, OP_SLT = 6'b100111;
   localparam logic [5:0] OP_SW = 6'b110000, OP_LW = 6'b110001;
   localparam logic [5:0] OP_BEQ = 6'b110100, OP_BNE = 6'b110101, OP_BLTZ = 6'b110110;
   localparam logic [5:0] OP_J = 6'b111000, OP_JR = 6'b111001, OP_JAL = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111, OP_NOP = 6'b111100;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw, irw, rw, asa, asb, dbs, rd, wr, wrd, ext;
      logic [1:0] rdst, pcs;
      logic [2:0] aop;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t ex;
   exp_t tr[32];
   logic chk_en = 1'b0;
   logic [2:0] seq[32];
   int   seq_len;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t op=%b)", name, act, want, $time, op);
      end
   endtask

   // 0 ALU, 1 lw, 2 sw, 3 branch, 4 j/jr/jal/nop, 5 halt
   function automatic int classify(input logic [5:0] o);
      if (o inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLTI, OP_SLT})
         return 0;
      if (o == OP_LW) return 1;
      if (o == OP_SW) return 2;
      if (o inside {OP_BEQ, OP_BNE, OP_BLTZ}) return 3;
      if (o == OP_HALT) return 5;
      return 4;
   endfunction

   task automatic build(input logic [5:0] o, input int halt_n);
      seq[0] = 3'b000;
      seq[1] = 3'b001;
      case (classify(o))
         0: begin seq[2] = 3'b110; seq[3] = 3'b111; seq_len = 4; end
         1: begin seq[2] = 3'b010; seq[3] = 3'b011; seq[4] = 3'b100; seq_len = 5; end
         2: begin seq[2] = 3'b010; seq[3] = 3'b011; seq_len = 4; end
         3: begin seq[2] = 3'b101; seq_len = 3; end
         5: begin
            for (int i = 2; i < halt_n + 3; i++) seq[i] = 3'b001;
            seq_len = halt_n + 3;
         end
         default: seq_len = 2;
      endcase
   endtask

   function automatic exp_t model(input logic [5:0] o, input int k, input logic rst,
                                  input logic z, input logic s);
      exp_t e;
      int   c;
      logic last, taken;
      c     = classify(o);
      last  = (k == seq_len - 1);
      taken = ((o == OP_BEQ) && z) || ((o == OP_BNE) && !z) || ((o == OP_BLTZ) && s);
      e     = '0;
      e.st  = seq[k];
      e.irw = (k == 0);
      e.pcw = (c != 5) && last;
      e.rw  = ((c == 0 || c == 1) && last) || (o == OP_JAL && k == 1);
      e.rd  = (c == 1) && (k == 3);
      e.wr  = (c == 2) && (k == 3);
      if (c == 3 && k == 2 && taken)              e.pcs = 2'b01;
      else if (k == 1 && (o == OP_J || o == OP_JAL)) e.pcs = 2'b11;
      else if (k == 1 && o == OP_JR)              e.pcs = 2'b10;
      if (o == OP_JAL) e.rdst = 2'b00;
      else if (o inside {OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT}) e.rdst = 2'b10;
      else e.rdst = 2'b01;
      e.wrd = (o != OP_JAL);
      e.dbs = (o == OP_LW);
      e.asa = (o == OP_SLL);
      e.asb = o inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW};
      e.ext = !(o == OP_ANDI || o == OP_ORI);
      if (o inside {OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ}) e.aop = 3'b001;
      else if (o inside {OP_AND, OP_ANDI})         e.aop = 3'b100;
      else if (o == OP_ORI)                        e.aop = 3'b011;
      else if (o == OP_SLL)                        e.aop = 3'b010;
      else if (o inside {OP_SLT, OP_SLTI})         e.aop = 3'b110;
      else                                         e.aop = 3'b000;
      if (rst) begin
         e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.rd = 1'b0; e.wr = 1'b0;
         e.pcs = 2'b00; e.aop = 3'b000;
      end
      return e;
   endfunction

   always @(negedge CLK) begin
      #2;
      if (chk_en) begin
         chk("state",     16'(state),     16'(ex.st));
         chk("PCWre",     16'(PCWre),     16'(ex.pcw));
         chk("IRWre",     16'(IRWre),     16'(ex.irw));
         chk("RegWre",    16'(RegWre),    16'(ex.rw));
         chk("ALUSrcA",   16'(ALUSrcA),   16'(ex.asa));
         chk("ALUSrcB",   16'(ALUSrcB),   16'(ex.asb));
         chk("DBDataSrc", 16'(DBDataSrc), 16'(ex.dbs));
         chk("mRD",       16'(mRD),       16'(ex.rd));
         chk("mWR",       16'(mWR),       16'(ex.wr));
         chk("WrRegDSrc", 16'(WrRegDSrc), 16'(ex.wrd));
         chk("ExtSel",    16'(ExtSel),    16'(ex.ext));
         chk("RegDst",    16'(RegDst),    16'(ex.rdst));
         chk("PCSrc",     16'(PCSrc),     16'(ex.pcs));
         chk("ALUOp",     16'(ALUOp),     16'(ex.aop));
      end
   end

   task automatic capture(input int k);
      tr[k].st = state;    tr[k].pcw = PCWre;   tr[k].irw = IRWre;  tr[k].rw = RegWre;
      tr[k].asa = ALUSrcA; tr[k].asb = ALUSrcB; tr[k].dbs = DBDataSrc;
      tr[k].rd = mRD;      tr[k].wr = mWR;      tr[k].wrd = WrRegDSrc; tr[k].ext = ExtSel;
      tr[k].rdst = RegDst; tr[k].pcs = PCSrc;   tr[k].aop = ALUOp;
   endtask

   // zm/sm: 0 or 1 hold that level, 2 randomizes every cycle; abort_k asserts Reset at that phase
   task automatic run_instr(input logic [5:0] o, input int zm, input int sm,
                            input int halt_n, input int abort_k);
      build(o, halt_n);
      if (classify(o) == 5) abort_k = seq_len - 1;
      for (int k = 0; k < seq_len; k++) begin
         @(negedge CLK);
         op    = o;
         zero  = (zm == 2) ? 1'($urandom_range(0, 1)) : (zm == 1);
         sign  = (sm == 2) ? 1'($urandom_range(0, 1)) : (sm == 1);
         Reset = (k == abort_k);
         ex    = model(o, k, Reset, zero, sign);
         chk_en = 1'b1;
         #3;
         capture(k);
         if (k == abort_k) break;
      end
   endtask

   logic [5:0] pool[18] = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL,
                            OP_SLTI, OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ,
                            OP_J, OP_JR, OP_JAL, OP_HALT};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] o;
      int         abort;
      Reset = 1'b1;
      op    = OP_NOP;
      @(negedge CLK);
      build(OP_NOP, 0);
      ex     = model(OP_NOP, 0, 1'b1, 1'b0, 1'b0);
      chk_en = 1'b1;

      run_instr(OP_ADD, 2, 2, 0, -1);
      chk("add_states", 16'({tr[0].st, tr[1].st, tr[2].st, tr[3].st}), 16'(12'b000_001_110_111));
      chk("add_regwre", 16'({tr[0].rw, tr[1].rw, tr[2].rw, tr[3].rw}), 16'(4'b0001));
      chk("add_pcwre",  16'({tr[0].pcw, tr[1].pcw, tr[2].pcw, tr[3].pcw}), 16'(4'b0001));
      chk("add_regdst", 16'(tr[3].rdst), 16'(2'b10));

      run_instr(OP_LW, 2, 2, 0, -1);
      chk("lw_states", 16'({tr[0].st, tr[1].st, tr[2].st, tr[3].st, tr[4].st}),
          16'(15'b000_001_010_011_100));
      chk("lw_mrd",    16'({tr[0].rd, tr[1].rd, tr[2].rd, tr[3].rd, tr[4].rd}), 16'(5'b00010));
      chk("lw_regwre", 16'({tr[0].rw, tr[1].rw, tr[2].rw, tr[3].rw, tr[4].rw}), 16'(5'b00001));
      chk("lw_dbsrc",  16'(tr[4].dbs), 16'(1'b1));

      run_instr(OP_SW, 2, 2, 0, -1);
      chk("sw_states", 16'({tr[0].st, tr[1].st, tr[2].st, tr[3].st}), 16'(12'b000_001_010_011));
      chk("sw_mwr",    16'(tr[3].wr), 16'(1'b1));
      chk("sw_pcwre",  16'(tr[3].pcw), 16'(1'b1));

      run_instr(OP_BEQ, 1, 2, 0, -1);
      chk("beq_t_state", 16'(tr[2].st), 16'(3'b101));
      chk("beq_t_pcsrc", 16'(tr[2].pcs), 16'(2'b01));
      chk("beq_t_pcwre", 16'(tr[2].pcw), 16'(1'b1));
      run_instr(OP_BEQ, 0, 2, 0, -1);
      chk("beq_nt_pcsrc", 16'(tr[2].pcs), 16'(2'b00));
      run_instr(OP_BLTZ, 2, 1, 0, -1);
      chk("bltz_t_pcsrc", 16'(tr[2].pcs), 16'(2'b01));

      run_instr(OP_JAL, 2, 2, 0, -1);
      chk("jal_regwre", 16'(tr[1].rw), 16'(1'b1));
      chk("jal_regdst", 16'(tr[1].rdst), 16'(2'b00));
      chk("jal_wrdsrc", 16'(tr[1].wrd), 16'(1'b0));
      chk("jal_pcsrc",  16'(tr[1].pcs), 16'(2'b11));
      chk("jal_pcwre",  16'(tr[1].pcw), 16'(1'b1));
      run_instr(OP_NOP, 2, 2, 0, -1);
      chk("after_jal_state", 16'(tr[0].st), 16'(3'b000));

      run_instr(OP_HALT, 2, 2, 12, -1);
      for (int k = 1; k <= 13; k++)
         chk("halt_park", 16'({tr[k].st, tr[k].pcw}), 16'({3'b001, 1'b0}));
      run_instr(OP_NOP, 2, 2, 0, -1);
      chk("after_halt_state", 16'(tr[0].st), 16'(3'b000));

      run_instr(OP_SW, 2, 2, 0, 3);
      chk("sw_abort_state", 16'(tr[3].st), 16'(3'b011));
      chk("sw_abort_mwr",   16'(tr[3].wr), 16'(1'b0));
      run_instr(OP_NOP, 2, 2, 0, -1);
      chk("after_abort_state", 16'(tr[0].st), 16'(3'b000));

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 5) == 0) o = 6'($urandom);
         else o = pool[$urandom_range(0, 17)];
         abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(o, 2, 2, int'($urandom_range(10, 13)), abort);
      end

      chk_en = 1'b0;
      @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
